rslatch: RTL and testbench
==========================

// Module: rslatch
// PURPOSE
//   Clocked, synthesizable model of a cross-coupled NAND RS latch.
//   Inputs s and r are active-low: q = ~(s & nq), nq = ~(r & q), evaluated once per clock.
//   Flags the forbidden both-active input state and resolves the release race deterministically.
//   Used as a leaf storage/flag element wherever set/clear requests arrive as active-low pulses.
// PARAMETERS
//   SYNC_STAGES  0      flops on s and r before evaluation; legal range 0..3, 0 = no synchronizer
//   RESET_Q      1'b0   value of q after reset; nq resets to ~RESET_Q
//   RACE_Q       1'b0   value q takes when both inputs release together from both-active
// PORTS
//   clk          in   1  single clock, all state updates on rising edge
//   rst          in   1  synchronous, active-high reset
//   s            in   1  set request, active-low (0 = set)
//   r            in   1  reset request, active-low (0 = clear)
//   q            out  1  latch output
//   nq           out  1  complementary output; equals ~q except in forbidden state
//   both_low     out  1  high while the sampled s=0 and r=0 (forbidden state)
//   race         out  1  one-cycle pulse when leaving forbidden state via s=1,r=1
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - On a clk edge with rst=1:
//     - q=RESET_Q, nq=~RESET_Q, both_low=0, race=0.
//     - All synchronizer flops load 1 (inactive).
//     - rst dominates s and r.
//   - Sampled inputs (ss, rs) are s/r delayed by SYNC_STAGES flops.
//   - Latency: an input change is visible on the outputs SYNC_STAGES+1 edges later.
//   - Next-state table on each edge with rst=0 (ss,rs -> q,nq):
//     - 0,1 -> 1,0  set
//     - 1,0 -> 0,1  clear
//     - 0,0 -> 1,1  forbidden state; both_low=1 next cycle
//     - 1,1 with previous q=nq=1 -> q=RACE_Q, nq=~RACE_Q; race=1 for exactly one cycle
//     - 1,1 otherwise -> hold q,nq
//   - both_low is registered; it equals (ss==0 && rs==0) from the same edge that updates q/nq.
//   - race is 0 on every other edge.
//   - Leaving the forbidden state by deasserting only one input (0,0 -> 0,1 or 1,0) does not pulse race.
//     - q/nq simply follow the table for the new input pair.
//   - Outputs are registers: no combinational path from s/r to q/nq, glitch-free.
//   - X on s/r is not propagated beyond simulation.
//     - Implementation treats any non-0 value as 1 (inactive).
//   - Reset asserted mid-sequence, including while in the forbidden state:
//     - Outputs go to reset values at that edge.
//     - No race pulse is generated on release of reset.
// TESTING
//   - Reset: rst=1 for 2 edges, s=r=1 -> q=0, nq=1, both_low=0, race=0 (RESET_Q=0).
//   - Sequence s,r = 00,10,00,01,00,11 (hold each 10 clk, SYNC_STAGES=0):
//     - 00 -> q,nq=1,1, both_low=1
//     - 10 -> q,nq=0,1
//     - 00 -> q,nq=1,1
//     - 01 -> q,nq=1,0
//     - 00 -> q,nq=1,1
//     - 11 -> q,nq=0,1 (RACE_Q=0), race high exactly one cycle, then hold 0,1
//   - Hold check: after set (01), drive 11 for 20 clk -> q=1, nq=0 stable, race=0 throughout.
//   - Latency: SYNC_STAGES=2, s falls at edge N -> q rises at edge N+3, not earlier.
//   - Reset mid-forbidden: s=r=0, then rst=1 and s=r=1 on the same edge.
//     - Outputs go to 0,1, race stays 0.
//   - One-sided exit: 00 -> 01 -> q,nq=1,0, race=0, both_low drops the same edge.

Source files
------------

// File: rtl/rslatch.sv
// Clocked model of a cross-coupled NAND RS latch with active-low set/clear,
// optional input synchronizer, forbidden-state flag and deterministic release.
module rslatch #(
    parameter int   SYNC_STAGES = 0,
    parameter logic RESET_Q     = 1'b0,
    parameter logic RACE_Q      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic nq,
    output logic both_low,
    output logic race
);

    logic s_in;
    logic r_in;
    logic ss;
    logic rs;

    logic q_reg;
    logic q_next;
    logic nq_reg;
    logic nq_next;
    logic both_low_reg;
    logic both_low_next;
    logic race_reg;
    logic race_next;

    // Only a clean 0 counts as an active request; X/Z in simulation fall to inactive.
    always_comb begin
        s_in = 1'b1;
        r_in = 1'b1;
        if (s == 1'b0) begin
            s_in = 1'b0;
        end
        if (r == 1'b0) begin
            r_in = 1'b0;
        end
    end

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ss = s_in;
            assign rs = r_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] s_pipe_reg;
            logic [SYNC_STAGES-1:0] r_pipe_reg;

            // Reset loads the inactive level so no stale request survives reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_pipe_reg <= '1;
                    r_pipe_reg <= '1;
                end else begin
                    s_pipe_reg[0] <= s_in;
                    r_pipe_reg[0] <= r_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        s_pipe_reg[i] <= s_pipe_reg[i-1];
                        r_pipe_reg[i] <= r_pipe_reg[i-1];
                    end
                end
            end

            assign ss = s_pipe_reg[SYNC_STAGES-1];
            assign rs = r_pipe_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        q_next        = q_reg;
        nq_next       = nq_reg;
        race_next     = 1'b0;
        both_low_next = ~ss & ~rs;
        case ({ss, rs})
            2'b01: begin
                q_next  = 1'b1;
                nq_next = 1'b0;
            end
            2'b10: begin
                q_next  = 1'b0;
                nq_next = 1'b1;
            end
            2'b00: begin
                q_next  = 1'b1;
                nq_next = 1'b1;
            end
            default: begin
                // Simultaneous release from the forbidden state: pick RACE_Q.
                if (q_reg && nq_reg) begin
                    q_next    = RACE_Q;
                    nq_next   = ~RACE_Q;
                    race_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg        <= RESET_Q;
            nq_reg       <= ~RESET_Q;
            both_low_reg <= 1'b0;
            race_reg     <= 1'b0;
        end else begin
            q_reg        <= q_next;
            nq_reg       <= nq_next;
            both_low_reg <= both_low_next;
            race_reg     <= race_next;
        end
    end

    assign q        = q_reg;
    assign nq       = nq_reg;
    assign both_low = both_low_reg;
    assign race     = race_reg;

endmodule

// File: tb/tb_rslatch.sv
// Bench for rslatch: three parameterisations driven with directed and random
// active-low set/clear traffic, checked against a history-based reference model.
module tb_rslatch;

    localparam int   NDUT = 3;
    localparam int   LAG   [NDUT] = '{0, 2, 1};
    localparam logic RQ    [NDUT] = '{1'b0, 1'b0, 1'b1};
    localparam logic RC    [NDUT] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s   = 1'b1;
    logic r   = 1'b1;

    logic q0, nq0, bl0, rc0;
    logic q1, nq1, bl1, rc1;
    logic q2, nq2, bl2, rc2;
    logic [3:0] obs [NDUT];

    int tests_run    = 0;
    int tests_failed = 0;
    int race_cnt     = 0;

    // Applied input history, one entry per clock edge.
    logic hs   [$];
    logic hr   [$];
    logic hrst [$];

    logic mq  [NDUT];
    logic mnq [NDUT];
    logic mbl [NDUT];
    logic mrc [NDUT];

    always #5 clk = ~clk;

    rslatch #(.SYNC_STAGES(0), .RESET_Q(1'b0), .RACE_Q(1'b0)) dut0 (
        .clk(clk), .rst(rst), .s(s), .r(r),
        .q(q0), .nq(nq0), .both_low(bl0), .race(rc0)
    );
    rslatch #(.SYNC_STAGES(2), .RESET_Q(1'b0), .RACE_Q(1'b0)) dut1 (
        .clk(clk), .rst(rst), .s(s), .r(r),
        .q(q1), .nq(nq1), .both_low(bl1), .race(rc1)
    );
    rslatch #(.SYNC_STAGES(1), .RESET_Q(1'b1), .RACE_Q(1'b1)) dut2 (
        .clk(clk), .rst(rst), .s(s), .r(r),
        .q(q2), .nq(nq2), .both_low(bl2), .race(rc2)
    );

    assign obs[0] = {q0, nq0, bl0, rc0};
    assign obs[1] = {q1, nq1, bl1, rc1};
    assign obs[2] = {q2, nq2, bl2, rc2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Input seen by a DUT with `lag` synchronizer stages at the newest edge:
    // the value applied lag edges ago, or inactive if reset hit the pipeline since.
    function automatic void eff_in(input int lag, output logic es, output logic er);
        int n;
        n  = hs.size() - 1;
        es = 1'b1;
        er = 1'b1;
        if (n - lag < 0) return;
        for (int m = n - lag; m < n; m++) begin
            if (hrst[m]) return;
        end
        es = hs[n-lag];
        er = hr[n-lag];
    endfunction

    function automatic void model_step(input int k, input logic rst_v);
        logic es, er;
        if (rst_v) begin
            mq[k]  = RQ[k];
            mnq[k] = ~RQ[k];
            mbl[k] = 1'b0;
            mrc[k] = 1'b0;
            return;
        end
        eff_in(LAG[k], es, er);
        mbl[k] = !es && !er;
        mrc[k] = 1'b0;
        if (!es && !er) begin
            mq[k] = 1'b1; mnq[k] = 1'b1;
        end else if (!es) begin
            mq[k] = 1'b1; mnq[k] = 1'b0;
        end else if (!er) begin
            mq[k] = 1'b0; mnq[k] = 1'b1;
        end else if (mq[k] && mnq[k]) begin
            mq[k] = RC[k]; mnq[k] = ~RC[k]; mrc[k] = 1'b1;
        end
    endfunction

    task automatic tick(input logic s_v, input logic r_v, input logic rst_v);
        s   = s_v;
        r   = r_v;
        rst = rst_v;
        @(posedge clk);
        hs.push_back(s_v);
        hr.push_back(r_v);
        hrst.push_back(rst_v);
        for (int k = 0; k < NDUT; k++) model_step(k, rst_v);
        #1;
        race_cnt += int'(rc0);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("dut%0d_edge%0d", k, hs.size() - 1), obs[k],
                  {mq[k], mnq[k], mbl[k], mrc[k]});
    endtask

    task automatic hold(input logic s_v, input logic r_v, input int n, input string name);
        for (int i = 0; i < n; i++) tick(s_v, r_v, 1'b0);
        $display("[TB] %s: s=%b r=%b x%0d -> dut0 q=%b nq=%b both_low=%b", name, s_v, r_v, n,
                 q0, nq0, bl0);
    endtask

    initial begin
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("reset_dut0", obs[0], 4'b0100);
        check("reset_dut2", obs[2], 4'b1000);
        $display("[TB] reset: q=%b nq=%b both_low=%b race=%b", q0, nq0, bl0, rc0);

        hold(1'b0, 1'b0, 10, "seq00");
        check("seq00_dut0", obs[0], 4'b1110);
        hold(1'b1, 1'b0, 10, "seq10");
        check("seq10_dut0", obs[0], 4'b0100);
        hold(1'b0, 1'b0, 10, "seq00b");
        hold(1'b0, 1'b1, 10, "seq01");
        check("seq01_dut0", obs[0], 4'b1000);
        hold(1'b0, 1'b0, 10, "seq00c");
        race_cnt = 0;
        hold(1'b1, 1'b1, 10, "seq11");
        check("race_pulse_count", race_cnt, 1);
        check("seq11_dut0", obs[0], 4'b0100);

        hold(1'b0, 1'b1, 5, "set");
        race_cnt = 0;
        hold(1'b1, 1'b1, 20, "hold11");
        check("hold_q_nq", obs[0], 4'b1000);
        check("hold_race_count", race_cnt, 0);

        hold(1'b0, 1'b0, 5, "forbid");
        race_cnt = 0;
        tick(1'b1, 1'b1, 1'b1);
        $display("[TB] reset mid-forbidden: q=%b nq=%b race=%b", q0, nq0, rc0);
        hold(1'b1, 1'b1, 10, "post_reset");
        check("rst_forbid_dut0", obs[0], 4'b0100);
        check("rst_forbid_race", race_cnt, 0);

        hold(1'b0, 1'b0, 5, "forbid2");
        race_cnt = 0;
        tick(1'b0, 1'b1, 1'b0);
        check("one_sided_exit", obs[0], 4'b1000);
        hold(1'b0, 1'b1, 4, "one_sided");
        check("one_sided_race", race_cnt, 0);

        for (int t = 0; t < 600; t++) begin
            logic s_v, r_v, rst_v;
            int   len;
            s_v   = 1'($urandom_range(0, 1));
            r_v   = 1'($urandom_range(0, 1));
            rst_v = ($urandom_range(0, 39) == 0);
            len   = $urandom_range(1, 4);
            tick(s_v, r_v, rst_v);
            for (int i = 1; i < len; i++) tick(s_v, r_v, 1'b0);
            $display("[TB] rand%0d: s=%b r=%b rst=%b x%0d -> q=%b%b%b nq=%b%b%b", t, s_v, r_v,
                     rst_v, len, q0, q1, q2, nq0, nq1, nq2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
